// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// The entry tag is sized for register addresses up to RD_W bits.
package hazard_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int DEPTH_DEF   = 3;
  localparam int ALU_RDY_DEF = 0;
  localparam int LD_RDY_DEF  = 1;

  localparam int RD_W   = 8;
  localparam int FWD_RF = 0;

  function automatic int selw(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int SELW = selw(DEPTH_DEF);

  typedef struct packed {
    logic            v;
    logic            ld;
    logic [RD_W-1:0] rd;
  } entry_t;

  // A producer in stage k has its value on res_data_i once k reaches its ready stage.
  function automatic logic stage_ready(input int k, input logic ld,
                                       input int alu_rdy = ALU_RDY_DEF,
                                       input int ld_rdy  = LD_RDY_DEF);
    return k >= (ld ? ld_rdy : alu_rdy);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_operand_resolver.sv
// One source-operand port: youngest-producer match, readiness check and data mux.
module operand_resolver
  import hazard_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ALU_RDY = ALU_RDY_DEF,
  parameter int LD_RDY  = LD_RDY_DEF,
  parameter int SEL_W   = selw(DEPTH)
) (
  input  logic [REG_AW-1:0]     rs_i,
  input  entry_t [DEPTH-1:0]    ent_i,
  input  logic [XLEN-1:0]       rf_data_i,
  input  logic [DEPTH*XLEN-1:0] res_data_i,
  output logic [XLEN-1:0]       opnd_o,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  stall_o
);

  logic found;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    opnd_o  = rf_data_i;
    sel_o   = SEL_W'(FWD_RF);
    stall_o = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && ent_i[k].v && (rs_i != '0) && (ent_i[k].rd == RD_W'(rs_i))) begin
        found   = 1'b1;
        opnd_o  = res_data_i[k*XLEN +: XLEN];
        sel_o   = SEL_W'(k + 1);
        stall_o = !stage_ready(k, ent_i[k].ld, ALU_RDY, LD_RDY);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding and load-use stall unit with its own in-flight tag pipeline,
// branch flush, global freeze and a saturating stall counter.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int N_RD        = 2,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ALU_RDY     = ALU_RDY_DEF,
  parameter int LD_RDY      = LD_RDY_DEF,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            id_valid_i,
  input  logic [N_RD*REG_AW-1:0]          id_rs_i,
  input  logic [REG_AW-1:0]               id_rd_i,
  input  logic                            id_we_i,
  input  logic                            id_load_i,
  input  logic [N_RD*XLEN-1:0]            rf_data_i,
  input  logic [DEPTH*XLEN-1:0]           res_data_i,
  input  logic                            freeze_i,
  input  logic                            flush_i,
  output logic [N_RD*XLEN-1:0]            opnd_o,
  output logic [N_RD*$clog2(DEPTH+1)-1:0] fwd_sel_o,
  output logic                            hazard_stall_o,
  output logic                            issue_o,
  output logic [DEPTH-1:0]                st_valid_o,
  output logic [31:0]                     stall_cnt_o
);

  localparam int SEL_W = selw(DEPTH);

  entry_t [DEPTH-1:0] st_q, st_d;
  entry_t             new_ent;
  logic   [31:0]      stall_cnt_q, stall_cnt_d;
  logic   [N_RD-1:0]  port_stall;

  for (genvar p = 0; p < N_RD; p++) begin : g_port
    operand_resolver #(
      .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH),
      .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .SEL_W(SEL_W)
    ) u_res (
      .rs_i       (id_rs_i[p*REG_AW +: REG_AW]),
      .ent_i      (st_q),
      .rf_data_i  (rf_data_i[p*XLEN +: XLEN]),
      .res_data_i (res_data_i),
      .opnd_o     (opnd_o[p*XLEN +: XLEN]),
      .sel_o      (fwd_sel_o[p*SEL_W +: SEL_W]),
      .stall_o    (port_stall[p])
    );
  end

  assign hazard_stall_o = id_valid_i && !flush_i && (|port_stall);
  assign issue_o        = id_valid_i && !hazard_stall_o && !freeze_i && !flush_i;

  // x0 and non-writing instructions never become producers.
  always_comb begin
    new_ent    = '0;
    new_ent.v  = id_we_i && (id_rd_i != '0);
    new_ent.ld = id_load_i;
    new_ent.rd = RD_W'(id_rd_i);
  end

  always_comb begin
    st_d = st_q;
    if (!freeze_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        st_d[k] = (flush_i && (k - 1) < FLUSH_DEPTH) ? '0 : st_q[k-1];
      end
      st_d[0] = issue_o ? new_ent : '0;
    end else if (flush_i) begin
      for (int k = 0; k < FLUSH_DEPTH; k++) begin
        st_d[k] = '0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_stall_o && !freeze_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; next-state logic lives in always_comb.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      st_valid_o[k] = st_q[k].v;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed vectors push expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_hazard_fwd_unit;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 3;
  localparam int SELW  = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  id_valid_i;
  logic [NRD*AW-1:0]     id_rs_i;
  logic [AW-1:0]         id_rd_i;
  logic                  id_we_i;
  logic                  id_load_i;
  logic [NRD*XLEN-1:0]   rf_data_i;
  logic [DEPTH*XLEN-1:0] res_data_i;
  logic                  freeze_i;
  logic                  flush_i;
  logic [NRD*XLEN-1:0]   opnd_o;
  logic [NRD*SELW-1:0]   fwd_sel_o;
  logic                  hazard_stall_o;
  logic                  issue_o;
  logic [DEPTH-1:0]      st_valid_o;
  logic [31:0]           stall_cnt_o;

  hazard_fwd_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
    .id_rd_i(id_rd_i), .id_we_i(id_we_i), .id_load_i(id_load_i),
    .rf_data_i(rf_data_i), .res_data_i(res_data_i), .freeze_i(freeze_i),
    .flush_i(flush_i), .opnd_o(opnd_o), .fwd_sel_o(fwd_sel_o),
    .hazard_stall_o(hazard_stall_o), .issue_o(issue_o),
    .st_valid_o(st_valid_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {K_OPND0, K_OPND1, K_SEL0, K_SEL1, K_STALL, K_ISSUE, K_STV, K_CNT} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] RF0 = 32'hF0F0_0000;
  localparam logic [31:0] RF1 = 32'h0F0F_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_OPND0: return opnd_o[0 +: XLEN];
      K_OPND1: return opnd_o[XLEN +: XLEN];
      K_SEL0:  return 32'(fwd_sel_o[0 +: SELW]);
      K_SEL1:  return 32'(fwd_sel_o[SELW +: SELW]);
      K_STALL: return 32'(hazard_stall_o);
      K_ISSUE: return 32'(issue_o);
      K_STV:   return 32'(st_valid_o);
      default: return stall_cnt_o;
    endcase
  endfunction

  // Monitor: the DUT's outputs are combinational, so every queued expectation is due mid-cycle.
  always @(negedge clk_i) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.name, observe(e.kind), e.exp);
    end
  end

  task automatic exp_push(input string n, input kind_e k, input logic [31:0] v);
    sb_q.push_back('{n, k, v});
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_valid_i = 1'b0; id_rs_i = '0; id_rd_i = '0; id_we_i = 1'b0;
    id_load_i  = 1'b0; freeze_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic issue_wr(input logic [AW-1:0] rd, input logic ld);
    idle();
    id_valid_i = 1'b1; id_rd_i = rd; id_we_i = 1'b1; id_load_i = ld;
  endtask

  task automatic consume(input logic [AW-1:0] rs0, input logic [AW-1:0] rs1);
    idle();
    id_valid_i = 1'b1; id_rs_i = {rs1, rs0};
  endtask

  initial begin
    rst_i      = 1'b0;
    rf_data_i  = {RF1, RF0};
    res_data_i = {32'hBBBB_0002, 32'hCCCC_0001, 32'hDDDD_0000};
    idle();
    repeat (2) step();
    rst_i = 1'b1;

    // Reset state
    consume(5'd3, 5'd0);
    exp_push("rst_stv", K_STV, 32'h0);
    exp_push("rst_cnt", K_CNT, 32'h0);
    exp_push("rst_opnd0", K_OPND0, RF0);
    exp_push("rst_sel0", K_SEL0, 32'd0);
    exp_push("rst_stall", K_STALL, 32'd0);
    exp_push("rst_issue", K_ISSUE, 32'd1);
    step();

    // ALU back-to-back
    drain();
    issue_wr(5'd5, 1'b0);
    exp_push("alu_issue", K_ISSUE, 32'd1);
    step();
    consume(5'd5, 5'd0);
    res_data_i[0 +: XLEN] = 32'h0000_1234;
    exp_push("alu_sel0", K_SEL0, 32'd1);
    exp_push("alu_opnd0", K_OPND0, 32'h0000_1234);
    exp_push("alu_stall", K_STALL, 32'd0);
    exp_push("alu_stv", K_STV, 32'b001);
    step();

    // Load-use
    drain();
    issue_wr(5'd6, 1'b1);
    step();
    consume(5'd0, 5'd6);
    res_data_i[XLEN +: XLEN] = 32'hCAFE_F00D;
    exp_push("lu_stall1", K_STALL, 32'd1);
    exp_push("lu_issue1", K_ISSUE, 32'd0);
    exp_push("lu_cnt0", K_CNT, 32'd0);
    step();
    exp_push("lu_cnt1", K_CNT, 32'd1);
    exp_push("lu_stall2", K_STALL, 32'd0);
    exp_push("lu_issue2", K_ISSUE, 32'd1);
    exp_push("lu_sel1", K_SEL1, 32'd2);
    exp_push("lu_opnd1", K_OPND1, 32'hCAFE_F00D);
    exp_push("lu_stv", K_STV, 32'b010);
    step();

    // Priority: youngest producer wins
    drain();
    issue_wr(5'd7, 1'b0); step();
    issue_wr(5'd9, 1'b0); step();
    issue_wr(5'd7, 1'b0); step();
    consume(5'd7, 5'd9);
    res_data_i = {32'h0000_BBBB, 32'h0000_9999, 32'h0000_AAAA};
    exp_push("pri_stv", K_STV, 32'b111);
    exp_push("pri_sel0", K_SEL0, 32'd1);
    exp_push("pri_opnd0", K_OPND0, 32'h0000_AAAA);
    exp_push("pri_sel1", K_SEL1, 32'd2);
    exp_push("pri_opnd1", K_OPND1, 32'h0000_9999);
    exp_push("pri_stall", K_STALL, 32'd0);
    step();

    // x0 is never a producer
    drain();
    issue_wr(5'd0, 1'b1); step();
    consume(5'd0, 5'd0);
    exp_push("x0_stv", K_STV, 32'b000);
    exp_push("x0_stall", K_STALL, 32'd0);
    exp_push("x0_sel0", K_SEL0, 32'd0);
    exp_push("x0_opnd0", K_OPND0, RF0);
    step();

    // Flush kills the youngest entry as it shifts
    drain();
    issue_wr(5'd8, 1'b0); step();
    consume(5'd8, 5'd0);
    flush_i = 1'b1;
    exp_push("fl_stv0", K_STV, 32'b001);
    exp_push("fl_stall", K_STALL, 32'd0);
    exp_push("fl_issue", K_ISSUE, 32'd0);
    step();
    consume(5'd8, 5'd0);
    exp_push("fl_stv1", K_STV, 32'b000);
    exp_push("fl_sel0", K_SEL0, 32'd0);
    exp_push("fl_opnd0", K_OPND0, RF0);
    step();

    // Freeze: stall not counted, no shift, flush clears in place
    drain();
    issue_wr(5'd10, 1'b1); step();
    consume(5'd10, 5'd0);
    freeze_i = 1'b1;
    exp_push("fz_stall", K_STALL, 32'd1);
    exp_push("fz_issue", K_ISSUE, 32'd0);
    step();
    idle();
    freeze_i = 1'b1;
    exp_push("fz_hold_stv", K_STV, 32'b001);
    exp_push("fz_hold_cnt", K_CNT, 32'd1);
    flush_i = 1'b1;
    step();
    consume(5'd10, 5'd0);
    exp_push("fz_fl_stv", K_STV, 32'b000);
    exp_push("fz_fl_sel0", K_SEL0, 32'd0);
    exp_push("fz_fl_stall", K_STALL, 32'd0);
    exp_push("fz_fl_cnt", K_CNT, 32'd1);
    step();

    // Reset mid-stall
    drain();
    issue_wr(5'd11, 1'b1); step();
    consume(5'd11, 5'd0);
    rst_i = 1'b0;
    exp_push("rs_stall_pre", K_STALL, 32'd1);
    step();
    rst_i = 1'b1;
    exp_push("rs_stall_post", K_STALL, 32'd0);
    exp_push("rs_stv", K_STV, 32'b000);
    exp_push("rs_cnt", K_CNT, 32'd0);
    step();

    idle();
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) step();
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised successor to the fixed 2-port forwarding unit; also performs load-use hazard detection.
- Tracks destination tags of every in-flight instruction from ID/EX through MEM/WB in its own shift register.
- Resolves each ID-stage source operand to either register-file data or the youngest in-flight result, and requests a stall when that result is not yet produced.
- Handles branch flush and global freeze, and keeps a stall performance counter.

Parameters:
- XLEN, 32: datapath width.
- REG_AW, 5: register address width.
- N_RD, 2: number of source-operand read ports.
- DEPTH, 3: tracked stages (0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB).
- ALU_RDY, 0: first stage index at which a non-load result is valid on res_data_i.
- LD_RDY, 1: first stage index at which a load result is valid on res_data_i.
- FLUSH_DEPTH, 1: number of youngest tracked entries killed by flush_i. Range 0..DEPTH.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low.
- id_valid_i  in  1  valid instruction in ID.
- id_rs_i  in  N_RD*REG_AW  source register indices, port p at [p*REG_AW +: REG_AW].
- id_rd_i  in  REG_AW  destination register.
- id_we_i  in  1  instruction writes id_rd_i.
- id_load_i  in  1  instruction is a load.
- rf_data_i  in  N_RD*XLEN  register-file read data, per port.
- res_data_i  in  DEPTH*XLEN  result value currently held in stage k.
- freeze_i  in  1  global pipeline hold.
- flush_i  in  1  branch taken; kill ID and the youngest FLUSH_DEPTH entries.
- opnd_o  out  N_RD*XLEN  resolved operand, per port.
- fwd_sel_o  out  N_RD*SELW  0 = register file, k+1 = stage k.
- hazard_stall_o  out  1  ID must hold; a bubble is inserted.
- issue_o  out  1  ID instruction enters stage 0 this cycle.
- st_valid_o  out  DEPTH  valid bit of each entry (debug).
- stall_cnt_o  out  32  saturating count of hazard stall cycles.

Behaviour:
- Entry fields per stage k: v, rd, ld.
  - An entry is written valid only if id_we_i=1 and id_rd_i!=0, so x0 is never a producer.
  - A non-writing issued instruction enters as v=0.
- Reset (rst_i=0 at a clock edge): all v=0, rd=0, ld=0, stall_cnt_o=0.
  - After reset, opnd_o=rf_data_i, fwd_sel_o=0, hazard_stall_o=0 and issue_o=id_valid_i.
- Port resolution is combinational, with zero latency:
  - match_k = v_k && rd_k==rs_p && rs_p!=0.
  - The lowest matching k (youngest) wins.
  - The selected entry is ready if k >= (ld_k ? LD_RDY : ALU_RDY).
  - Ready: opnd = res_data_i[k], sel = k+1.
  - No match or rs_p=0: opnd = rf_data_i (x0 gives 0 via the register file), sel = 0.
  - Not ready: the port raises a stall; opnd and sel are still driven as if ready, but the values are don't-care.
- hazard_stall_o = id_valid_i && !flush_i && OR(port stalls).
- issue_o = id_valid_i && !hazard_stall_o && !freeze_i && !flush_i.
- Clock edge, freeze_i=0:
  - Entries 0..FLUSH_DEPTH-1 are cleared if flush_i=1.
  - Entry k+1 <= entry k, and entry DEPTH-1 retires.
  - Entry 0 <= issue_o ? new tag : bubble (v=0).
- Clock edge, freeze_i=1:
  - No shift; entries hold.
  - If flush_i=1, entries 0..FLUSH_DEPTH-1 are still cleared in place.
- stall_cnt_o increments on each edge with hazard_stall_o=1 and freeze_i=0; it holds at 0xFFFFFFFF.
- Same-cycle WB write and ID read are covered because stage DEPTH-1 forwards; there is no register-file write-through dependency.
- Reset has priority over flush and freeze. Reset mid-stall clears the stall on the next cycle.

Decomposition:
- Package hazard_pkg holds:
  - SELW = clog2(DEPTH+1).
  - FWD_RF = 0.
  - A packed entry typedef {v, ld, rd}.
  - Helper function stage_ready(k, ld).
- Sub-module operand_resolver handles one read port: priority match, ready check, data mux. It is instantiated N_RD times via generate.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles, then release -> st_valid_o=000, stall_cnt_o=0, rs1=x3 gives opnd_o=rf_data_i, fwd_sel_o=0.
- ALU back-to-back: issue add x5, then rs1=x5 with res_data_i[0]=0x00001234 -> fwd_sel=1, opnd=0x00001234, hazard_stall_o=0.
- Load-use: issue lw x6, then rs2=x6.
  - Cycle 1: hazard_stall_o=1, issue_o=0, stall_cnt_o becomes 1.
  - Cycle 2: fwd_sel=2, opnd=res_data_i[1]=0xCAFEF00D, issue_o=1.
- Priority: x7 is a producer in stage 0 (0xAAAA) and stage 2 (0xBBBB) -> opnd=0xAAAA, fwd_sel=1.
- x0: issue lw x0, then rs1=x0 -> no stall, st_valid_o[0]=0 after issue, fwd_sel=0.
- Flush and freeze:
  - Entry 0 holds x8 with flush_i=1 -> next cycle st_valid_o[1]=0 and a consumer of x8 gets sel=0.
  - Repeat with freeze_i=1 -> entry 0 cleared in place, no shift, stall_cnt_o unchanged.
